// File: rtl/regfile_flags.sv
// regfile_flags: operand/writeback stage around the 8-bit ALU.
//
// Holds a NREGS x 8-bit register file, the {N,Z,C} status register and a
// shadow copy of it for interrupt entry/return. It also provides 16-bit
// pointer-pair post-increment for load/store addressing.
//
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data and
// the flag value being loaded onto the outputs. Storage is identical in both
// builds. When the macro is not defined, every output comes from stored state.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ra_addr/ra_data    combinational read port A (to ALU dataA)
//   rb_addr/rb_data    combinational read port B (to ALU dataB)
//   wr_en/addr/data    synchronous write port
//   flag_we + *_alu    latch ALU C/Z/N
//   flags_wr/din       direct {N,Z,C} load (POP F)
//   int_save           copy flags -> shadow
//   int_restore        copy shadow -> flags
//   pair_inc/pair_sel  post-increment pair {reg[2p+1], reg[2p]}
//   pair_addr          selected pair value
//   carry/zero/neg     individual flags
//   flags_out          {N,Z,C}
module regfile_flags #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra_addr,
    output logic [7:0]    ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [7:0]    rb_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          flag_we,
    input  logic          cin_alu,
    input  logic          zin_alu,
    input  logic          nin_alu,
    input  logic          flags_wr,
    input  logic [2:0]    flags_din,
    input  logic          int_save,
    input  logic          int_restore,
    input  logic          pair_inc,
    input  logic [AW-2:0] pair_sel,
    output logic [15:0]   pair_addr,
    output logic          carry,
    output logic          zero,
    output logic          neg,
    output logic [2:0]    flags_out
);

    logic [7:0]    regs_q [NREGS];
    logic [7:0]    regs_d [NREGS];
    logic [2:0]    flags_q, flags_d;
    logic [2:0]    shadow_q, shadow_d;
    logic [AW-1:0] pair_lo, pair_hi;
    logic [15:0]   pair_cur, pair_next;
    logic          pair_hit;

    // Register file next state. A write into either byte of the selected
    // pair cancels the whole increment. A write elsewhere coexists with it.
    always_comb begin
        pair_lo   = {pair_sel, 1'b0};
        pair_hi   = {pair_sel, 1'b1};
        pair_cur  = {regs_q[pair_hi], regs_q[pair_lo]};
        pair_next = pair_cur + 16'd1;
        pair_hit  = wr_en && ((wr_addr == pair_lo) || (wr_addr == pair_hi));
        regs_d    = regs_q;
        if (pair_inc && !pair_hit) begin
            regs_d[pair_lo] = pair_next[7:0];
            regs_d[pair_hi] = pair_next[15:8];
        end
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Flag next state: restore > direct load > ALU > hold.
    // The shadow always samples the pre-edge flags, so save+restore swaps.
    always_comb begin
        flags_d = flags_q;
        if (int_restore) begin
            flags_d = shadow_q;
        end else if (flags_wr) begin
            flags_d = flags_din;
        end else if (flag_we) begin
            flags_d = {nin_alu, zin_alu, cin_alu};
        end
        shadow_d = int_save ? flags_q : shadow_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            flags_q  <= '0;
            shadow_q <= '0;
        end else begin
            regs_q   <= regs_d;
            flags_q  <= flags_d;
            shadow_q <= shadow_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        ra_data = (wr_en && (ra_addr == wr_addr)) ? wr_data : regs_q[ra_addr];
        rb_data = (wr_en && (rb_addr == wr_addr)) ? wr_data : regs_q[rb_addr];
        pair_addr[7:0]  = (wr_en && (wr_addr == pair_lo)) ? wr_data : regs_q[pair_lo];
        pair_addr[15:8] = (wr_en && (wr_addr == pair_hi)) ? wr_data : regs_q[pair_hi];
        flags_out = flags_d;
    end
`else
    always_comb begin
        ra_data   = regs_q[ra_addr];
        rb_data   = regs_q[rb_addr];
        pair_addr = pair_cur;
        flags_out = flags_q;
    end
`endif

    assign carry = flags_out[0];
    assign zero  = flags_out[1];
    assign neg   = flags_out[2];

endmodule

// File: tb/tb_regfile_flags.sv
// Testbench for regfile_flags. It applies directed vectors first, then
// randomized cycles checked against a behavioural model. The model is an
// array of registers plus flag and shadow values.
module tb_regfile_flags;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ra_addr, rb_addr, wr_addr;
    logic [7:0]  ra_data, rb_data, wr_data;
    logic        wr_en, flag_we, cin_alu, zin_alu, nin_alu, flags_wr;
    logic [2:0]  flags_din, flags_out;
    logic        int_save, int_restore, pair_inc;
    logic [2:0]  pair_sel;
    logic [15:0] pair_addr;
    logic        carry, zero, neg;

    int errors = 0;
    int checks = 0;

    bit [7:0] mreg [16];
    bit [2:0] mflags, mshadow;
    bit       model_valid = 0;

    regfile_flags #(.NREGS(16), .AW(4)) dut (
        .clk(clk), .rst(rst),
        .ra_addr(ra_addr), .ra_data(ra_data),
        .rb_addr(rb_addr), .rb_data(rb_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .flag_we(flag_we), .cin_alu(cin_alu), .zin_alu(zin_alu), .nin_alu(nin_alu),
        .flags_wr(flags_wr), .flags_din(flags_din),
        .int_save(int_save), .int_restore(int_restore),
        .pair_inc(pair_inc), .pair_sel(pair_sel), .pair_addr(pair_addr),
        .carry(carry), .zero(zero), .neg(neg), .flags_out(flags_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       we;
        bit [3:0] wa;
        bit [7:0] wd;
        bit       fwe;
        bit [2:0] alu;   // {N,Z,C} from ALU
        bit       fwr;
        bit [2:0] fdin;
        bit       sv;
        bit       rs;
        bit       inc;
        bit [2:0] ps;
        bit [3:0] ra;
        bit [3:0] rb;
        bit [7:0] e_ra;
        bit [7:0] e_rb;
        bit [15:0] e_pair;
        bit [2:0] e_fl;
    } vec_t;

    function automatic vec_t mk(bit r, bit we, bit [3:0] wa, bit [7:0] wd,
                                bit fwe, bit [2:0] alu, bit fwr, bit [2:0] fdin,
                                bit sv, bit rs, bit inc, bit [2:0] ps,
                                bit [3:0] ra, bit [3:0] rb, bit [7:0] e_ra,
                                bit [7:0] e_rb, bit [15:0] e_pair, bit [2:0] e_fl);
        vec_t v;
        v.rst = r; v.we = we; v.wa = wa; v.wd = wd; v.fwe = fwe; v.alu = alu;
        v.fwr = fwr; v.fdin = fdin; v.sv = sv; v.rs = rs; v.inc = inc; v.ps = ps;
        v.ra = ra; v.rb = rb; v.e_ra = e_ra; v.e_rb = e_rb; v.e_pair = e_pair;
        v.e_fl = e_fl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Value the model says a read of address a shows while the inputs are applied.
    function automatic bit [7:0] exp_rd(bit [3:0] a);
`ifdef REGFILE_BYPASS_EN
        if (wr_en && a == wr_addr) return wr_data;
`endif
        return mreg[a];
    endfunction

    function automatic bit [2:0] next_flags();
        if (int_restore) return mshadow;
        if (flags_wr)    return flags_din;
        if (flag_we)     return {nin_alu, zin_alu, cin_alu};
        return mflags;
    endfunction

    function automatic bit [2:0] exp_fl_now();
`ifdef REGFILE_BYPASS_EN
        return next_flags();
`else
        return mflags;
`endif
    endfunction

    task automatic model_edge();
        int lo, hi, v;
        bit [2:0] nf;
        if (rst) begin
            foreach (mreg[i]) mreg[i] = 8'h00;
            mflags = 3'b000;
            mshadow = 3'b000;
            model_valid = 1;
            return;
        end
        lo = 2 * int'(pair_sel);
        hi = lo + 1;
        nf = next_flags();
        if (int_save) mshadow = mflags;
        mflags = nf;
        if (pair_inc && !(wr_en && (int'(wr_addr) == lo || int'(wr_addr) == hi))) begin
            v = (int'(mreg[hi]) * 256 + int'(mreg[lo]) + 1) % 65536;
            mreg[lo] = 8'(v % 256);
            mreg[hi] = 8'(v / 256);
        end
        if (wr_en) mreg[wr_addr] = wr_data;
    endtask

    task automatic check_model(input string tag);
        bit [3:0] lo;
        bit [3:0] hi;
        bit [2:0] ef;
        lo = {pair_sel, 1'b0};
        hi = {pair_sel, 1'b1};
        ef = exp_fl_now();
        chk({tag, "_ra"}, {8'h00, ra_data}, {8'h00, exp_rd(ra_addr)});
        chk({tag, "_rb"}, {8'h00, rb_data}, {8'h00, exp_rd(rb_addr)});
        chk({tag, "_pair"}, pair_addr, {exp_rd(hi), exp_rd(lo)});
        chk({tag, "_flags"}, {13'h0, flags_out}, {13'h0, ef});
        chk({tag, "_nzc"}, {13'h0, neg, zero, carry}, {13'h0, ef});
    endtask

    task automatic step(input vec_t v);
        rst = v.rst; wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
        flag_we = v.fwe; {nin_alu, zin_alu, cin_alu} = v.alu;
        flags_wr = v.fwr; flags_din = v.fdin;
        int_save = v.sv; int_restore = v.rs; pair_inc = v.inc;
        pair_sel = v.ps; ra_addr = v.ra; rb_addr = v.rb;
        #1;
        if (model_valid && !v.rst) check_model("pre");
        @(posedge clk);
        model_edge();
        #1;
        rst = 0; wr_en = 0; flag_we = 0; flags_wr = 0;
        int_save = 0; int_restore = 0; pair_inc = 0;
        #1;
        check_model("post");
    endtask

    vec_t vecs[$];

    initial begin
        vec_t rv;
        rst = 1; wr_en = 0; wr_addr = 0; wr_data = 0; flag_we = 0;
        cin_alu = 0; zin_alu = 0; nin_alu = 0; flags_wr = 0; flags_din = 0;
        int_save = 0; int_restore = 0; pair_inc = 0; pair_sel = 0;
        ra_addr = 0; rb_addr = 0;

        //           rst we wa  wd     fwe alu     fwr fdin    sv rs inc ps ra  rb   e_ra   e_rb   e_pair     e_fl
        vecs.push_back(mk(1, 0, 0,  8'h00, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0,  0,  8'h00, 8'h00, 16'h0000, 3'b000));
        vecs.push_back(mk(0, 1, 3,  8'hA5, 0, 3'b000, 0, 3'b000, 0, 0, 0, 1, 3,  0,  8'hA5, 8'h00, 16'hA500, 3'b000));
        vecs.push_back(mk(0, 0, 0,  8'h00, 0, 3'b000, 1, 3'b111, 0, 0, 0, 1, 3,  0,  8'hA5, 8'h00, 16'hA500, 3'b111));
        vecs.push_back(mk(1, 1, 3,  8'h77, 1, 3'b111, 0, 3'b000, 1, 0, 1, 1, 3,  0,  8'h00, 8'h00, 16'h0000, 3'b000));
        vecs.push_back(mk(0, 1, 5,  8'h3C, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 5,  5,  8'h3C, 8'h3C, 16'h0000, 3'b000));
        vecs.push_back(mk(0, 1, 14, 8'hFF, 0, 3'b000, 0, 3'b000, 0, 0, 0, 7, 14, 15, 8'hFF, 8'h00, 16'h00FF, 3'b000));
        vecs.push_back(mk(0, 0, 0,  8'h00, 0, 3'b000, 0, 3'b000, 0, 0, 1, 7, 14, 15, 8'h00, 8'h01, 16'h0100, 3'b000));
        vecs.push_back(mk(0, 1, 14, 8'hFF, 0, 3'b000, 0, 3'b000, 0, 0, 0, 7, 14, 15, 8'hFF, 8'h01, 16'h01FF, 3'b000));
        vecs.push_back(mk(0, 1, 15, 8'hFF, 0, 3'b000, 1, 3'b101, 0, 0, 0, 7, 14, 15, 8'hFF, 8'hFF, 16'hFFFF, 3'b101));
        vecs.push_back(mk(0, 0, 0,  8'h00, 0, 3'b000, 0, 3'b000, 0, 0, 1, 7, 14, 15, 8'h00, 8'h00, 16'h0000, 3'b101));
        vecs.push_back(mk(0, 1, 14, 8'hFF, 0, 3'b000, 0, 3'b000, 0, 0, 0, 7, 14, 15, 8'hFF, 8'h00, 16'h00FF, 3'b101));
        vecs.push_back(mk(0, 1, 15, 8'h12, 0, 3'b000, 0, 3'b000, 0, 0, 1, 7, 14, 15, 8'hFF, 8'h12, 16'h12FF, 3'b101));
        vecs.push_back(mk(0, 0, 0,  8'h00, 0, 3'b000, 1, 3'b000, 0, 0, 0, 7, 14, 15, 8'hFF, 8'h12, 16'h12FF, 3'b000));
        vecs.push_back(mk(0, 0, 0,  8'h00, 1, 3'b101, 0, 3'b000, 0, 0, 0, 7, 14, 15, 8'hFF, 8'h12, 16'h12FF, 3'b101));
        vecs.push_back(mk(0, 0, 0,  8'h00, 1, 3'b101, 1, 3'b010, 0, 0, 0, 7, 14, 15, 8'hFF, 8'h12, 16'h12FF, 3'b010));
        vecs.push_back(mk(0, 0, 0,  8'h00, 0, 3'b000, 1, 3'b001, 0, 0, 0, 7, 14, 15, 8'hFF, 8'h12, 16'h12FF, 3'b001));
        vecs.push_back(mk(0, 0, 0,  8'h00, 1, 3'b110, 0, 3'b000, 1, 0, 0, 7, 14, 15, 8'hFF, 8'h12, 16'h12FF, 3'b110));
        vecs.push_back(mk(0, 0, 0,  8'h00, 0, 3'b000, 1, 3'b111, 0, 1, 0, 7, 14, 15, 8'hFF, 8'h12, 16'h12FF, 3'b001));
        vecs.push_back(mk(0, 0, 0,  8'h00, 0, 3'b000, 1, 3'b011, 0, 0, 0, 7, 14, 15, 8'hFF, 8'h12, 16'h12FF, 3'b011));
        vecs.push_back(mk(0, 0, 0,  8'h00, 0, 3'b000, 0, 3'b000, 1, 0, 0, 7, 14, 15, 8'hFF, 8'h12, 16'h12FF, 3'b011));
        vecs.push_back(mk(0, 0, 0,  8'h00, 0, 3'b000, 1, 3'b100, 0, 0, 0, 7, 14, 15, 8'hFF, 8'h12, 16'h12FF, 3'b100));
        vecs.push_back(mk(0, 0, 0,  8'h00, 0, 3'b000, 0, 3'b000, 1, 1, 0, 7, 14, 15, 8'hFF, 8'h12, 16'h12FF, 3'b011));
        vecs.push_back(mk(0, 0, 0,  8'h00, 0, 3'b000, 0, 3'b000, 0, 1, 0, 7, 14, 15, 8'hFF, 8'h12, 16'h12FF, 3'b100));
        vecs.push_back(mk(0, 1, 0,  8'h5A, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0,  15, 8'h5A, 8'h12, 16'h005A, 3'b100));

        foreach (vecs[i]) begin
            step(vecs[i]);
            chk($sformatf("vec%0d_ra", i), {8'h00, ra_data}, {8'h00, vecs[i].e_ra});
            chk($sformatf("vec%0d_rb", i), {8'h00, rb_data}, {8'h00, vecs[i].e_rb});
            chk($sformatf("vec%0d_pair", i), pair_addr, vecs[i].e_pair);
            chk($sformatf("vec%0d_flags", i), {13'h0, flags_out}, {13'h0, vecs[i].e_fl});
        end

        // Randomized cycles: write addresses and pair selects are biased
        // toward collisions so that suppression and forwarding get exercised.
        for (int n = 0; n < 400; n++) begin
            rv.rst  = ($urandom_range(0, 59) == 0);
            rv.we   = $urandom_range(0, 1) == 1;
            rv.ps   = 3'($urandom_range(0, 7));
            rv.wa   = ($urandom_range(0, 2) == 0) ? {rv.ps, 1'($urandom_range(0, 1))}
                                                  : 4'($urandom_range(0, 15));
            rv.wd   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            rv.fwe  = $urandom_range(0, 1) == 1;
            rv.alu  = 3'($urandom_range(0, 7));
            rv.fwr  = $urandom_range(0, 3) == 0;
            rv.fdin = 3'($urandom_range(0, 7));
            rv.sv   = $urandom_range(0, 3) == 0;
            rv.rs   = $urandom_range(0, 3) == 0;
            rv.inc  = $urandom_range(0, 1) == 1;
            rv.ra   = ($urandom_range(0, 2) == 0) ? rv.wa : 4'($urandom_range(0, 15));
            rv.rb   = ($urandom_range(0, 2) == 0) ? rv.wa : 4'($urandom_range(0, 15));
            rv.e_ra = 0; rv.e_rb = 0; rv.e_pair = 0; rv.e_fl = 0;
            step(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
